// File: rtl/muxn_scan_if.sv
// muxn_scan bus: channel data, select/mode/hold controls and registered results.
// Defining MUXN_SCAN_PARITY_EN adds the par output.
interface muxn_scan_if #(
   parameter int N = 8,
   parameter int W = 1
);
   localparam int SW = $clog2(N);

   logic [N*W-1:0] I;
   logic [SW-1:0]  S;
   logic           mode;
   logic           hold;
   logic [W-1:0]   Y;
   logic           valid;
   logic [SW-1:0]  ch;
   logic           wrap;
   logic           sel_err;
`ifdef MUXN_SCAN_PARITY_EN
   logic           par;

   modport master (
      output I, S, mode, hold,
      input  Y, valid, ch, wrap, sel_err, par
   );
   modport slave (
      input  I, S, mode, hold,
      output Y, valid, ch, wrap, sel_err, par
   );
`else
   modport master (
      output I, S, mode, hold,
      input  Y, valid, ch, wrap, sel_err
   );
   modport slave (
      input  I, S, mode, hold,
      output Y, valid, ch, wrap, sel_err
   );
`endif
endinterface

// File: rtl/muxn_scan.sv
// N-channel registered mux with manual select and dwell-timed auto-scan.
// Optional MUXN_SCAN_PARITY_EN adds a registered even-parity output par.
module muxn_scan #(
   parameter int N     = 8,
   parameter int W     = 1,
   parameter int DWELL = 2
) (
   input  logic clk,
   input  logic rst,
   muxn_scan_if.slave bus
);
   localparam int SW = $clog2(N);
   localparam logic [SW:0]   NL = (SW+1)'(N);
   localparam logic [SW-1:0] PL = SW'(N-1);
   localparam logic [7:0]    DL = 8'(DWELL-1);

   typedef enum logic {MANUAL, SCAN} st_t;

   st_t           st, st_n;
   logic [SW-1:0] p, p_n, eff_p;
   logic [7:0]    d, d_n, eff_d;
   logic [W-1:0]  y_q, y_n;
   logic [SW-1:0] ch_q, ch_n;
   logic          v_q, v_n;
   logic          wrap_q, wrap_n;
   logic          err_q, err_n;
   logic          pend, pend_n;
   logic          s_ok;

   function automatic logic [W-1:0] pick(
      input logic [N*W-1:0] v,
      input logic [SW-1:0]  k
   );
      logic [W-1:0] r;
      r = '0;
      for (int j = 0; j < N; j++)
         if (int'(k) == j) r = v[j*W +: W];
      return r;
   endfunction

   assign s_ok = {1'b0, bus.S} < NL;

   always_comb begin
      st_n   = st;
      p_n    = p;
      d_n    = d;
      y_n    = y_q;
      ch_n   = ch_q;
      v_n    = v_q;
      wrap_n = 1'b0;
      err_n  = err_q;
      pend_n = pend;
      eff_p  = p;
      eff_d  = d;
      if (!bus.hold) begin
         if (bus.mode) begin
            st_n = SCAN;
            if (st == MANUAL) begin
               eff_p = s_ok ? bus.S : '0;
               eff_d = '0;
            end
            y_n    = pick(bus.I, eff_p);
            ch_n   = eff_p;
            v_n    = 1'b1;
            wrap_n = pend;
            if (eff_d == DL) begin
               d_n    = '0;
               p_n    = (eff_p == PL) ? '0 : eff_p + SW'(1);
               pend_n = (eff_p == PL);
            end else begin
               d_n    = eff_d + 8'd1;
               p_n    = eff_p;
               pend_n = 1'b0;
            end
         end else begin
            st_n   = MANUAL;
            y_n    = s_ok ? pick(bus.I, bus.S) : '0;
            ch_n   = s_ok ? bus.S : '0;
            v_n    = 1'b1;
            err_n  = !s_ok;
            pend_n = 1'b0;
            p_n    = '0;
            d_n    = '0;
         end
      end
   end

   // Reset parks in SCAN with p=0 so a scan after reset starts at channel 0,
   // not at S as a fresh manual->scan entry would.
   always_ff @(posedge clk) begin
      if (rst) begin
         st     <= SCAN;
         p      <= '0;
         d      <= '0;
         y_q    <= '0;
         ch_q   <= '0;
         v_q    <= 1'b0;
         wrap_q <= 1'b0;
         err_q  <= 1'b0;
         pend   <= 1'b0;
      end else begin
         st     <= st_n;
         p      <= p_n;
         d      <= d_n;
         y_q    <= y_n;
         ch_q   <= ch_n;
         v_q    <= v_n;
         wrap_q <= wrap_n;
         err_q  <= err_n;
         pend   <= pend_n;
      end
   end

   assign bus.Y       = y_q;
   assign bus.valid   = v_q;
   assign bus.ch      = ch_q;
   assign bus.wrap    = wrap_q;
   assign bus.sel_err = err_q;

`ifdef MUXN_SCAN_PARITY_EN
   logic par_q;

   always_ff @(posedge clk) begin
      if (rst) par_q <= 1'b0;
      else     par_q <= ^y_n;
   end

   assign bus.par = par_q;
`endif
endmodule

// File: tb/tb_muxn_scan.sv
// Scoreboard bench for muxn_scan: two configurations driven in lockstep,
// expectations from a tick-count scan model, directed cases then random.
module tb_muxn_scan;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   muxn_scan_if #(.N(8), .W(1)) b0 ();
   muxn_scan_if #(.N(6), .W(4)) b1 ();

   muxn_scan #(.N(8), .W(1), .DWELL(2)) u0 (
      .clk (clk),
      .rst (rst),
      .bus (b0)
   );
   muxn_scan #(.N(6), .W(4), .DWELL(3)) u1 (
      .clk (clk),
      .rst (rst),
      .bus (b1)
   );

   typedef struct {
      logic [31:0] y;
      logic        v;
      logic [3:0]  ch;
      logic        wrap;
      logic        err;
      logic        par;
   } exp_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   s0[2];
   int   k[2];
   bit   insc[2];
   exp_t last[2];
   exp_t q0[$];
   exp_t q1[$];
   logic par0, par1;

`ifdef MUXN_SCAN_PARITY_EN
   assign par0 = b0.par;
   assign par1 = b1.par;
`else
   assign par0 = 1'b0;
   assign par1 = 1'b0;
`endif

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] field(input logic [31:0] i, input int c,
                                         input int w);
      logic [31:0] m;
      m = (32'd1 << w) - 32'd1;
      return (i >> (c * w)) & m;
   endfunction

   // Scan position is start channel plus elapsed dwell periods, modulo n.
   task automatic model(input int x, input int n, input int w, input int dw,
                        input logic r, input logic m, input logic h,
                        input logic [2:0] s, input logic [31:0] i);
      exp_t e;
      int   c;
      e = last[x];
      if (r) begin
         e = '{default: '0};
         insc[x] = 1'b1;
         s0[x] = 0;
         k[x] = 0;
      end else if (h) begin
         e.wrap = 1'b0;
      end else if (m) begin
         if (!insc[x]) begin
            s0[x] = (int'(s) < n) ? int'(s) : 0;
            k[x] = 0;
            insc[x] = 1'b1;
         end
         c = (s0[x] + k[x] / dw) % n;
         e.y = field(i, c, w);
         e.ch = 4'(c);
         e.v = 1'b1;
         e.wrap = (k[x] > 0) && (k[x] % dw == 0) && (c == 0);
         k[x]++;
      end else begin
         insc[x] = 1'b0;
         e.v = 1'b1;
         e.wrap = 1'b0;
         if (int'(s) < n) begin
            e.y = field(i, int'(s), w);
            e.ch = 4'(s);
            e.err = 1'b0;
         end else begin
            e.y = '0;
            e.ch = '0;
            e.err = 1'b1;
         end
      end
      e.par = ^e.y;
      last[x] = e;
      if (x == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   task automatic step(input logic r, input logic m, input logic h,
                       input logic [2:0] s, input logic [31:0] i);
      @(negedge clk);
      rst = r;
      b0.mode = m;
      b1.mode = m;
      b0.hold = h;
      b1.hold = h;
      b0.S = s;
      b1.S = s;
      b0.I = i[7:0];
      b1.I = i[23:0];
      model(0, 8, 1, 2, r, m, h, s, i);
      model(1, 6, 4, 3, r, m, h, s, i);
   endtask

   task automatic look();
      @(posedge clk);
      #2;
   endtask

   task automatic cmp(input string p, input exp_t e, input logic [31:0] y,
                      input logic v, input logic [3:0] c, input logic wr,
                      input logic er, input logic pa);
      chk({p, ".Y"}, y, e.y);
      chk({p, ".valid"}, 32'(v), 32'(e.v));
      chk({p, ".ch"}, 32'(c), 32'(e.ch));
      chk({p, ".wrap"}, 32'(wr), 32'(e.wrap));
      chk({p, ".sel_err"}, 32'(er), 32'(e.err));
`ifdef MUXN_SCAN_PARITY_EN
      chk({p, ".par"}, 32'(pa), 32'(e.par));
`else
      if (pa !== 1'b0) chk({p, ".par_tie"}, 32'(pa), 32'd0);
`endif
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         cmp("u0", e, 32'(b0.Y), b0.valid, 4'(b0.ch), b0.wrap,
             b0.sel_err, par0);
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         cmp("u1", e, 32'(b1.Y), b1.valid, 4'(b1.ch), b1.wrap,
             b1.sel_err, par1);
      end
   end

   int sw_y[8]  = '{0, 1, 1, 0, 1, 1, 0, 1};
   int sc_ch[7] = '{6, 6, 7, 7, 0, 0, 1};
   int sc_wr[7] = '{0, 0, 0, 0, 1, 0, 0};

   initial begin
      logic m;
      rst = 1'b1;
      b0.mode = 0; b1.mode = 0;
      b0.hold = 0; b1.hold = 0;
      b0.S = '0;   b1.S = '0;
      b0.I = '0;   b1.I = '0;
      step(1, 0, 0, 0, 0);
      look();
      chk("rst.Y", 32'(b0.Y), 0);
      chk("rst.valid", 32'(b0.valid), 0);
      chk("rst.ch", 32'(b0.ch), 0);

      for (int j = 0; j < 8; j++) begin
         step(0, 0, 0, 3'(j), 32'hb6);
         look();
         chk("sweep.Y", 32'(b0.Y), 32'(sw_y[j]));
         chk("sweep.sel_err", 32'(b0.sel_err), 0);
      end

      step(0, 0, 0, 3, 32'hb6);
      look();
      chk("data.Y_before", 32'(b0.Y), 0);
      step(0, 0, 0, 3, 32'hcb);
      look();
      chk("data.Y_after", 32'(b0.Y), 1);
      chk("data.ch", 32'(b0.ch), 3);

      step(0, 0, 0, 6, 32'hb6);
      for (int j = 0; j < 7; j++) begin
         step(0, 1, 0, 6, 32'hb6);
         look();
         chk("scan.ch", 32'(b0.ch), 32'(sc_ch[j]));
         chk("scan.wrap", 32'(b0.wrap), 32'(sc_wr[j]));
      end
      step(0, 1, 0, 6, 32'hb6);
      step(0, 1, 0, 6, 32'hb6);
      look();
      chk("hold.pre_ch", 32'(b0.ch), 2);
      for (int j = 0; j < 3; j++) begin
         step(0, 1, 1, 6, 32'hb6);
         look();
         chk("hold.ch", 32'(b0.ch), 2);
         chk("hold.Y", 32'(b0.Y), 1);
         chk("hold.wrap", 32'(b0.wrap), 0);
      end
      step(0, 1, 0, 6, 32'hb6);
      look();
      chk("hold.resume_ch", 32'(b0.ch), 2);
      step(0, 1, 0, 6, 32'hb6);
      look();
      chk("hold.next_ch", 32'(b0.ch), 3);

      repeat (4) step(0, 1, 0, 6, 32'hb6);
      look();
      chk("rstmid.pre_ch", 32'(b0.ch), 5);
      step(1, 1, 0, 6, 32'hb6);
      look();
      chk("rstmid.Y", 32'(b0.Y), 0);
      chk("rstmid.valid", 32'(b0.valid), 0);
      chk("rstmid.ch", 32'(b0.ch), 0);
      step(0, 1, 0, 6, 32'hb6);
      look();
      chk("rstmid.ch0a", 32'(b0.ch), 0);
      step(0, 1, 0, 6, 32'hb6);
      step(0, 1, 0, 6, 32'hb6);
      look();
      chk("rstmid.ch1", 32'(b0.ch), 1);

      step(0, 0, 0, 7, 32'h0);
      look();
      chk("oor.Y", 32'(b1.Y), 0);
      chk("oor.ch", 32'(b1.ch), 0);
      chk("oor.sel_err", 32'(b1.sel_err), 1);
      step(0, 0, 0, 2, 32'h00000b00);
      look();
      chk("oor.clear", 32'(b1.sel_err), 0);
      chk("oor.Y2", 32'(b1.Y), 32'hb);
`ifdef MUXN_SCAN_PARITY_EN
      chk("par.1011", 32'(b1.par), 1);
`endif

      m = 1'b0;
      for (int j = 0; j < 600; j++) begin
         if ($urandom_range(0, 9) == 0) m = ~m;
         step(($urandom_range(0, 39) == 0), m, ($urandom_range(0, 5) == 0),
              3'($urandom_range(0, 7)), $urandom);
      end

      repeat (2) @(posedge clk);
      #3;
      chk("drain.q0", 32'(q0.size()), 0);
      chk("drain.q1", 32'(q1.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
